multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: EN_EXT, default 1, meaning: 1 decodes ADDI/SUBI/B/CBNZ in addition to the base set; 0 treats them as illegal.
REQ-002 Parameter: WAIT_MAX, default 15, meaning: maximum consecutive cycles a memory state waits for mem_ready before trapping (WAIT_MAX >= 1).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: Op  input  11  instruction opcode field, taken from the instruction register.
REQ-006 Port: mem_ready  input  1  memory completion strobe for the current access.
REQ-007 Port: PCWrite, IRWrite  output  1 each  update PC; load the instruction register.
REQ-008 Port: Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  datapath controls.
REQ-009 Port: Branch, BranchNZ, UncondBranch  output  1 each  conditional branch on zero, on nonzero, and unconditional branch.
REQ-010 Port: ALUOp  output  2  00 add, 01 pass-B/compare, 10 funct-decoded.
REQ-011 Port: trap  output  1  sticky error flag.
REQ-012 Port: trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout.
REQ-013 Port: state  output  4  current state encoding, for debug.

Function
REQ-014 Moore FSM: every output is a function of the registered state only, except IRWrite and PCWrite, which also depend on mem_ready.
REQ-015 Encodings: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, MEMADR=4, MEMRD=5, LDWB=6, MEMWR=7, BRANCH=8, TRAP=15.
REQ-016 Every output not listed as asserted in a state is 0.
REQ-017 FETCH: MemRead=1; if mem_ready, IRWrite=1 and PCWrite=1 in that cycle and next=DECODE; otherwise stay.
REQ-018 DECODE: classify Op (casez) and go to: R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) -> EXEC; ADDI 1001000100?, SUBI 1101000100? -> EXEC; LDUR 11111000010, STUR 11111000000 -> MEMADR; CBZ 10110100???, CBNZ 10110101???, B 000101????? -> BRANCH; anything else -> TRAP with cause 01.
REQ-019 With EN_EXT=0, ADDI/SUBI/CBNZ/B take the illegal path.
REQ-020 Op is sampled only in DECODE; it is also re-read in EXEC/MEMADR/BRANCH, and the datapath holds IR stable there.
REQ-021 EXEC: ALUOp=10; ALUSrc=1 for ADDI/SUBI, else 0; next=ALUWB.
REQ-022 ALUWB: RegWrite=1, ALUOp held as in EXEC; next=FETCH.
REQ-023 MEMADR: ALUSrc=1, ALUOp=00, Reg2Loc=1 for STUR; next=MEMRD for LDUR, MEMWR for STUR.
REQ-024 MEMRD: MemRead=1 until mem_ready, then next=LDWB.
REQ-025 LDWB: MemtoReg=1, RegWrite=1; next=FETCH.
REQ-026 MEMWR: MemWrite=1, Reg2Loc=1 until mem_ready, then next=FETCH.
REQ-027 BRANCH outputs: CBZ gives Reg2Loc=1, ALUOp=01, Branch=1; CBNZ gives Reg2Loc=1, ALUOp=01, BranchNZ=1; B gives UncondBranch=1; PCWrite=1 for all three.
REQ-028 BRANCH: the datapath qualifies PCWrite with the branch condition; next=FETCH.
REQ-029 Wait counter, width $clog2(WAIT_MAX+1): cleared on entering FETCH, MEMRD or MEMWR; increments each cycle the state is held without mem_ready; saturates.
REQ-030 Timeout: in FETCH/MEMRD/MEMWR, if mem_ready=0 and the counter equals WAIT_MAX-1, next=TRAP with cause 10.
REQ-031 Timeout: mem_ready=1 in that same cycle wins over the timeout.
REQ-032 TRAP: all datapath controls 0, trap=1; stays until reset; trap_cause is held.
REQ-033 Instruction latency: R-type/immediate 4 cycles, LDUR 5, STUR 4, branch 3, each counted with zero memory wait states and including FETCH.

Reset
REQ-034 reset=1 at a clock edge forces state=FETCH, wait counter=0, trap=0, trap_cause=00, from any state including mid-wait and TRAP.
REQ-035 While reset is asserted, outputs reflect FETCH with IRWrite/PCWrite forced to 0.
REQ-036 The first fetch starts in the cycle after reset deasserts.

Verification
REQ-037 ADD 10001011000, mem_ready always 1 -> states 0,1,2,3,0; RegWrite=1 only in ALUWB; ALUOp=10 in EXEC.
REQ-038 LDUR, mem_ready delayed 3 cycles in MEMRD -> MemRead held 4 cycles, then LDWB with MemtoReg=1 and RegWrite=1 for exactly 1 cycle.
REQ-039 CBNZ with EN_EXT=1 -> BRANCH with BranchNZ=1, Branch=0; with EN_EXT=0 -> TRAP, trap_cause=01.
REQ-040 mem_ready held low in MEMWR, WAIT_MAX=15 -> TRAP on the 16th cycle after entry, trap_cause=10, MemWrite=0 thereafter.
REQ-041 mem_ready arriving exactly in the timeout cycle -> normal progress, no trap.
REQ-042 reset pulsed mid-MEMRD and again while in TRAP -> next state FETCH, trap=0, counter=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: Moore FSM that sequences fetch, decode, ALU, memory and
// branch steps, with a memory-wait watchdog and a sticky trap state.
module multicycle_ctrl #(
   parameter int EN_EXT   = 1,
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        Reg2Loc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Branch,
   output logic        BranchNZ,
   output logic        UncondBranch,
   output logic [1:0]  ALUOp,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [3:0]  state
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WAIT_MAX);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ALUWB  = 4'd3,
      S_MEMADR = 4'd4,
      S_MEMRD  = 4'd5,
      S_LDWB   = 4'd6,
      S_MEMWR  = 4'd7,
      S_BRANCH = 4'd8,
      S_TRAP   = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      C_ILL, C_RTYPE, C_IMM, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B
   } iclass_t;

   typedef struct packed {
      logic       reg2loc;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       branchnz;
      logic       uncond;
      logic       brpc;
      logic [1:0] aluop;
   } ctl_t;

   // Extension opcodes fall into the illegal class when EN_EXT is 0.
   function automatic iclass_t classify(input logic [10:0] op);
      iclass_t c;
      c = C_ILL;
      casez (op)
         11'b10001011000, 11'b11001011000,
         11'b10001010000, 11'b10101010000: c = C_RTYPE;
         11'b1001000100?, 11'b1101000100?: c = (EN_EXT != 0) ? C_IMM : C_ILL;
         11'b11111000010:                  c = C_LDUR;
         11'b11111000000:                  c = C_STUR;
         11'b10110100???:                  c = C_CBZ;
         11'b10110101???:                  c = (EN_EXT != 0) ? C_CBNZ : C_ILL;
         11'b000101?????:                  c = (EN_EXT != 0) ? C_B : C_ILL;
         default:                          c = C_ILL;
      endcase
      return c;
   endfunction

   function automatic ctl_t decode_ctl(input state_t s, input iclass_t c);
      ctl_t k;
      k = '0;
      case (s)
         S_FETCH:  k.memread = 1'b1;
         S_EXEC: begin
            k.aluop  = 2'b10;
            k.alusrc = (c == C_IMM);
         end
         S_ALUWB: begin
            k.aluop    = 2'b10;
            k.regwrite = 1'b1;
         end
         S_MEMADR: begin
            k.alusrc  = 1'b1;
            k.reg2loc = (c == C_STUR);
         end
         S_MEMRD:  k.memread = 1'b1;
         S_LDWB: begin
            k.memtoreg = 1'b1;
            k.regwrite = 1'b1;
         end
         S_MEMWR: begin
            k.memwrite = 1'b1;
            k.reg2loc  = 1'b1;
         end
         S_BRANCH: begin
            k.brpc     = 1'b1;
            k.uncond   = (c == C_B);
            k.branch   = (c == C_CBZ);
            k.branchnz = (c == C_CBNZ);
            if (c != C_B) begin
               k.reg2loc = 1'b1;
               k.aluop   = 2'b01;
            end
         end
         default:  k = '0;
      endcase
      return k;
   endfunction

   state_t        cur, nxt;
   iclass_t       cls;
   ctl_t          ctl_q;
   logic [CW-1:0] wait_cnt;
   logic          waiting, timeout;

   assign cls     = classify(Op);
   assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
   // A ready strobe in the last allowed cycle beats the watchdog.
   assign timeout = waiting && !mem_ready && (wait_cnt == CNT_LAST);

   always_comb begin
      nxt = cur;
      case (cur)
         S_FETCH:  if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (cls)
               C_RTYPE, C_IMM:     nxt = S_EXEC;
               C_LDUR, C_STUR:     nxt = S_MEMADR;
               C_CBZ, C_CBNZ, C_B: nxt = S_BRANCH;
               default:            nxt = S_TRAP;
            endcase
         end
         S_EXEC:   nxt = S_ALUWB;
         S_ALUWB:  nxt = S_FETCH;
         S_MEMADR: nxt = (cls == C_LDUR) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) nxt = S_LDWB;
         S_LDWB:   nxt = S_FETCH;
         S_MEMWR:  if (mem_ready) nxt = S_FETCH;
         S_BRANCH: nxt = S_FETCH;
         S_TRAP:   nxt = S_TRAP;
         default:  nxt = S_TRAP;
      endcase
      if (timeout) nxt = S_TRAP;
   end

   // Datapath controls are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur        <= S_FETCH;
         wait_cnt   <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
         ctl_q      <= decode_ctl(S_FETCH, C_ILL);
      end else begin
         cur   <= nxt;
         ctl_q <= decode_ctl(nxt, cls);
         trap  <= (nxt == S_TRAP);
         if ((nxt == S_TRAP) && (cur != S_TRAP))
            trap_cause <= timeout ? 2'b10 : 2'b01;
         if (((nxt == S_FETCH) || (nxt == S_MEMRD) || (nxt == S_MEMWR)) && (nxt != cur))
            wait_cnt <= '0;
         else if (waiting && !mem_ready && (wait_cnt != CNT_SAT))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign state        = cur;
   assign IRWrite      = !reset && (cur == S_FETCH) && mem_ready;
   assign PCWrite      = !reset && (((cur == S_FETCH) && mem_ready) || ctl_q.brpc);
   assign Reg2Loc      = ctl_q.reg2loc;
   assign ALUSrc       = ctl_q.alusrc;
   assign MemtoReg     = ctl_q.memtoreg;
   assign RegWrite     = ctl_q.regwrite;
   assign MemRead      = ctl_q.memread;
   assign MemWrite     = ctl_q.memwrite;
   assign Branch       = ctl_q.branch;
   assign BranchNZ     = ctl_q.branchnz;
   assign UncondBranch = ctl_q.uncond;
   assign ALUOp        = ctl_q.aluop;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one full-featured instance and one with the
// extension opcodes disabled, driven from shared inputs.
module tb_multicycle_ctrl;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_CBNZ = 11'b10110101011;
   localparam logic [10:0] OP_B    = 11'b00010100110;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_ready = 1'b1;
   logic [10:0] Op = '0;

   logic       PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic       Branch, BranchNZ, UncondBranch, trap;
   logic [1:0] ALUOp, trap_cause;
   logic [3:0] state;

   logic       PCWrite0, IRWrite0, Reg2Loc0, ALUSrc0, MemtoReg0, RegWrite0, MemRead0, MemWrite0;
   logic       Branch0, BranchNZ0, UncondBranch0, trap0;
   logic [1:0] ALUOp0, trap_cause0;
   logic [3:0] state0;

   int checks = 0;
   int passes = 0;
   int n;

   multicycle_ctrl #(.EN_EXT(1), .WAIT_MAX(15)) dut (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .BranchNZ(BranchNZ), .UncondBranch(UncondBranch), .ALUOp(ALUOp),
      .trap(trap), .trap_cause(trap_cause), .state(state)
   );

   multicycle_ctrl #(.EN_EXT(0), .WAIT_MAX(15)) dut0 (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(PCWrite0), .IRWrite(IRWrite0), .Reg2Loc(Reg2Loc0), .ALUSrc(ALUSrc0),
      .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .MemRead(MemRead0), .MemWrite(MemWrite0),
      .Branch(Branch0), .BranchNZ(BranchNZ0), .UncondBranch(UncondBranch0), .ALUOp(ALUOp0),
      .trap(trap0), .trap_cause(trap_cause0), .state(state0)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic applyStimulus(input logic [10:0] op, input logic ready);
      Op        = op;
      mem_ready = ready;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Time-based backstop in case an FSM wedges somewhere unexpected.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, with mem_ready high to show IRWrite/PCWrite are suppressed.
      applyStimulus(OP_ADD, 1'b1);
      tick();
      tick();
      checkOutput("rst_state", 16'(state), 16'd0);
      checkOutput("rst_memread", 16'(MemRead), 16'd1);
      checkOutput("rst_irwrite", 16'(IRWrite), 16'd0);
      checkOutput("rst_pcwrite", 16'(PCWrite), 16'd0);
      checkOutput("rst_trap", 16'(trap), 16'd0);
      checkOutput("rst_cause", 16'(trap_cause), 16'd0);
      checkOutput("rst_state0", 16'(state0), 16'd0);

      // ADD: 0,1,2,3,0
      reset = 1'b0;
      #1;
      checkOutput("add_irwrite", 16'(IRWrite), 16'd1);
      checkOutput("add_pcwrite", 16'(PCWrite), 16'd1);
      tick();
      checkOutput("add_decode", 16'(state), 16'd1);
      checkOutput("add_dec_regwrite", 16'(RegWrite), 16'd0);
      tick();
      checkOutput("add_exec", 16'(state), 16'd2);
      checkOutput("add_exec_aluop", 16'(ALUOp), 16'd2);
      checkOutput("add_exec_alusrc", 16'(ALUSrc), 16'd0);
      checkOutput("add_exec_regwrite", 16'(RegWrite), 16'd0);
      tick();
      checkOutput("add_aluwb", 16'(state), 16'd3);
      checkOutput("add_wb_regwrite", 16'(RegWrite), 16'd1);
      checkOutput("add_wb_aluop", 16'(ALUOp), 16'd2);
      tick();
      checkOutput("add_done", 16'(state), 16'd0);
      checkOutput("add_done_regwrite", 16'(RegWrite), 16'd0);

      // CBNZ: branch on the extended core, illegal on the base core
      applyStimulus(OP_CBNZ, 1'b1);
      tick();
      tick();
      checkOutput("cbnz_state", 16'(state), 16'd8);
      checkOutput("cbnz_branchnz", 16'(BranchNZ), 16'd1);
      checkOutput("cbnz_branch", 16'(Branch), 16'd0);
      checkOutput("cbnz_pcwrite", 16'(PCWrite), 16'd1);
      checkOutput("cbnz_aluop", 16'(ALUOp), 16'd1);
      checkOutput("cbnz0_state", 16'(state0), 16'd15);
      checkOutput("cbnz0_trap", 16'(trap0), 16'd1);
      checkOutput("cbnz0_cause", 16'(trap_cause0), 16'd1);
      tick();
      checkOutput("cbnz_done", 16'(state), 16'd0);
      checkOutput("cbnz0_sticky", 16'(state0), 16'd15);

      // ADDI uses the immediate operand
      applyStimulus(OP_ADDI, 1'b1);
      tick();
      tick();
      checkOutput("addi_exec", 16'(state), 16'd2);
      checkOutput("addi_alusrc", 16'(ALUSrc), 16'd1);
      tick();
      checkOutput("addi_wb_alusrc", 16'(ALUSrc), 16'd0);
      checkOutput("addi_wb_regwrite", 16'(RegWrite), 16'd1);
      tick();
      checkOutput("addi_done", 16'(state), 16'd0);

      // LDUR with three wait cycles in MEMRD
      applyStimulus(OP_LDUR, 1'b1);
      tick();
      tick();
      checkOutput("ldur_memadr", 16'(state), 16'd4);
      checkOutput("ldur_adr_alusrc", 16'(ALUSrc), 16'd1);
      checkOutput("ldur_adr_reg2loc", 16'(Reg2Loc), 16'd0);
      applyStimulus(OP_LDUR, 1'b0);
      tick();
      for (int i = 1; i <= 4; i++) begin
         checkOutput("ldur_memrd_state", 16'(state), 16'd5);
         checkOutput("ldur_memrd_read", 16'(MemRead), 16'd1);
         if (i == 4) applyStimulus(OP_LDUR, 1'b1);
         tick();
      end
      checkOutput("ldur_ldwb", 16'(state), 16'd6);
      checkOutput("ldur_memtoreg", 16'(MemtoReg), 16'd1);
      checkOutput("ldur_regwrite", 16'(RegWrite), 16'd1);
      checkOutput("ldur_wb_memread", 16'(MemRead), 16'd0);
      tick();
      checkOutput("ldur_done", 16'(state), 16'd0);
      checkOutput("ldur_done_regwrite", 16'(RegWrite), 16'd0);

      // STUR with immediate ready
      applyStimulus(OP_STUR, 1'b1);
      tick();
      tick();
      checkOutput("stur_adr_reg2loc", 16'(Reg2Loc), 16'd1);
      tick();
      checkOutput("stur_memwr", 16'(state), 16'd7);
      checkOutput("stur_memwrite", 16'(MemWrite), 16'd1);
      tick();
      checkOutput("stur_done", 16'(state), 16'd0);

      // CBZ
      applyStimulus(OP_CBZ, 1'b1);
      tick();
      tick();
      checkOutput("cbz_state", 16'(state), 16'd8);
      checkOutput("cbz_branch", 16'(Branch), 16'd1);
      checkOutput("cbz_branchnz", 16'(BranchNZ), 16'd0);
      checkOutput("cbz_reg2loc", 16'(Reg2Loc), 16'd1);
      tick();
      checkOutput("cbz_done", 16'(state), 16'd0);

      // STUR where ready arrives exactly in the timeout cycle
      applyStimulus(OP_STUR, 1'b1);
      tick();
      applyStimulus(OP_STUR, 1'b0);
      tick();
      tick();
      checkOutput("edge_memwr", 16'(state), 16'd7);
      for (int i = 1; i <= 15; i++) begin
         if (i == 15) applyStimulus(OP_STUR, 1'b1);
         tick();
      end
      checkOutput("edge_state", 16'(state), 16'd0);
      checkOutput("edge_trap", 16'(trap), 16'd0);

      // STUR with ready never arriving
      applyStimulus(OP_STUR, 1'b1);
      tick();
      applyStimulus(OP_STUR, 1'b0);
      tick();
      tick();
      n = 0;
      while (state == 4'd7 && n < 40) begin
         n++;
         tick();
      end
      checkOutput("to_memwr_cycles", 16'(n), 16'd15);
      checkOutput("to_state", 16'(state), 16'd15);
      checkOutput("to_trap", 16'(trap), 16'd1);
      checkOutput("to_cause", 16'(trap_cause), 16'd2);
      checkOutput("to_memwrite", 16'(MemWrite), 16'd0);
      applyStimulus(OP_ADD, 1'b1);
      tick();
      tick();
      checkOutput("to_sticky", 16'(state), 16'd15);
      checkOutput("to_sticky_cause", 16'(trap_cause), 16'd2);

      // Reset while trapped
      reset = 1'b1;
      tick();
      checkOutput("rtrap_state", 16'(state), 16'd0);
      checkOutput("rtrap_trap", 16'(trap), 16'd0);
      checkOutput("rtrap_cause", 16'(trap_cause), 16'd0);
      checkOutput("rtrap_irwrite", 16'(IRWrite), 16'd0);
      checkOutput("rtrap_pcwrite", 16'(PCWrite), 16'd0);
      checkOutput("rtrap_state0", 16'(state0), 16'd0);
      checkOutput("rtrap_trap0", 16'(trap0), 16'd0);
      reset = 1'b0;
      #1;
      checkOutput("rtrap_irwrite_after", 16'(IRWrite), 16'd1);

      // Reset mid-MEMRD, then a full fetch timeout from a clean counter
      applyStimulus(OP_LDUR, 1'b1);
      tick();
      tick();
      applyStimulus(OP_LDUR, 1'b0);
      tick();
      tick();
      tick();
      tick();
      checkOutput("rmem_memrd", 16'(state), 16'd5);
      reset = 1'b1;
      tick();
      checkOutput("rmem_state", 16'(state), 16'd0);
      checkOutput("rmem_trap", 16'(trap), 16'd0);
      checkOutput("rmem_memread", 16'(MemRead), 16'd1);
      reset = 1'b0;
      n = 0;
      while (state == 4'd0 && n < 40) begin
         n++;
         tick();
      end
      checkOutput("fetch_to_cycles", 16'(n), 16'd15);
      checkOutput("fetch_to_cause", 16'(trap_cause), 16'd2);

      // B: unconditional on the extended core, illegal on the base core
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(OP_B, 1'b1);
      tick();
      tick();
      checkOutput("b_state", 16'(state), 16'd8);
      checkOutput("b_uncond", 16'(UncondBranch), 16'd1);
      checkOutput("b_branch", 16'(Branch), 16'd0);
      checkOutput("b_aluop", 16'(ALUOp), 16'd0);
      checkOutput("b_pcwrite", 16'(PCWrite), 16'd1);
      checkOutput("b0_state", 16'(state0), 16'd15);
      checkOutput("b0_cause", 16'(trap_cause0), 16'd1);
      tick();
      checkOutput("b_done", 16'(state), 16'd0);
      checkOutput("b_done_pcwrite", 16'(PCWrite), 16'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
